// File: rtl/wrr_burst_scheduler.sv
// Weighted round-robin burst scheduler: grants one shared slave port to one requester per burst,
// letting a requester win up to cfg_weight consecutive bursts before priority rotates.
module wrr_burst_scheduler #(
    parameter int unsigned N        = 4,
    parameter int unsigned WEIGHT_W = 3,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic                    clk,
    input  logic                    rst_an,
    input  logic [N-1:0]            req,
    input  logic [N-1:0]            last,
    input  logic                    slv_ready,
    input  logic [N*WEIGHT_W-1:0]   cfg_weight,
    output logic [N-1:0]            grant,
    output logic [$clog2(N)-1:0]    gnt_idx,
    output logic                    busy,
    output logic                    beat,
    output logic                    abort
);

    localparam int unsigned IW = $clog2(N);
    localparam int unsigned TW = $clog2(TIMEOUT);

    typedef enum logic {StIdle, StBusy} state_t;

    state_t              state;
    logic [IW-1:0]       ptr;
    logic [WEIGHT_W-1:0] cnt;
    logic [TW-1:0]       tcnt;

    logic                win_found;
    logic [IW-1:0]       win_idx;
    logic [IW-1:0]       cand;
    int unsigned         cand_sum;
    logic [WEIGHT_W-1:0] wfield [N];
    logic [WEIGHT_W-1:0] win_weight;
    logic [IW-1:0]       next_after_owner;
    logic                owner_req;
    logic                owner_last;

    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            wfield[i] = cfg_weight[i*WEIGHT_W +: WEIGHT_W];
        end
    end

    // First requester at or above ptr, wrapping; lower offsets take precedence.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_sum  = 0;
        cand      = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand_sum = 32'(ptr) + k;
            if (cand_sum >= N) begin
                cand_sum = cand_sum - N;
            end
            cand = cand_sum[IW-1:0];
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        win_weight = (wfield[win_idx] == '0) ? WEIGHT_W'(1) : wfield[win_idx];
        next_after_owner = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
        owner_req  = req[gnt_idx];
        owner_last = last[gnt_idx];
    end

    assign busy = |grant;
    assign beat = busy & owner_req & slv_ready;

    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            state   <= StIdle;
            grant   <= '0;
            gnt_idx <= '0;
            abort   <= 1'b0;
            ptr     <= '0;
            cnt     <= '0;
            tcnt    <= '0;
        end else begin
            abort <= 1'b0;
            case (state)
                StIdle: begin
                    if (win_found) begin
                        grant   <= N'(1) << win_idx;
                        gnt_idx <= win_idx;
                        tcnt    <= '0;
                        state   <= StBusy;
                        // Credit survives only when the same requester wins again mid-turn.
                        if (win_idx != gnt_idx || cnt == '0) begin
                            cnt <= win_weight;
                        end
                    end
                end
                StBusy: begin
                    if (beat && owner_last) begin
                        grant <= '0;
                        state <= StIdle;
                        tcnt  <= '0;
                        if (cnt > WEIGHT_W'(1)) begin
                            cnt <= cnt - WEIGHT_W'(1);
                            ptr <= gnt_idx;
                        end else begin
                            cnt <= '0;
                            ptr <= next_after_owner;
                        end
                    end else if (owner_req) begin
                        tcnt <= '0;
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        grant <= '0;
                        state <= StIdle;
                        ptr   <= next_after_owner;
                        cnt   <= '0;
                        tcnt  <= '0;
                        abort <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_wrr_burst_scheduler.sv
// Self-checking bench for wrr_burst_scheduler: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural arbitration model.
module tb_wrr_burst_scheduler;

    localparam int N  = 4;
    localparam int WW = 3;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_an;
    logic [N-1:0]  req;
    logic [N-1:0]  last;
    logic          slv_ready;
    logic [N*WW-1:0] cfg_weight;
    logic [N-1:0]  grant;
    logic [1:0]    gnt_idx;
    logic          busy;
    logic          beat;
    logic          abort;

    always #5 clk = ~clk;

    wrr_burst_scheduler #(
        .N        (N),
        .WEIGHT_W (WW),
        .TIMEOUT  (TO)
    ) dut (
        .clk        (clk),
        .rst_an     (rst_an),
        .req        (req),
        .last       (last),
        .slv_ready  (slv_ready),
        .cfg_weight (cfg_weight),
        .grant      (grant),
        .gnt_idx    (gnt_idx),
        .busy       (busy),
        .beat       (beat),
        .abort      (abort)
    );

    int errs   = 0;
    int checks = 0;

    // Model: owner (-1 when idle), rotation pointer, remaining turn credit, previous winner,
    // run of consecutive low-request cycles of the owner, and the abort pulse.
    int m_owner;
    int m_ptr;
    int m_cred;
    int m_prev;
    int m_low;
    bit m_abort;
    bit cmp_en = 1'b0;

    int beat_cnt;
    int abort_seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int eff(input int i);
        int v;
        v = int'((cfg_weight >> (i * WW)) & 12'h7);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_cred  = 0;
        m_prev  = 0;
        m_low   = 0;
        m_abort = 1'b0;
    endtask

    task automatic model_step();
        int  w;
        bit  found;
        m_abort = 1'b0;
        if (m_owner < 0) begin
            found = 1'b0;
            w = 0;
            for (int k = 0; k < N; k++) begin
                if (!found && req[(m_ptr + k) % N]) begin
                    found = 1'b1;
                    w = (m_ptr + k) % N;
                end
            end
            if (found) begin
                if (w != m_prev || m_cred == 0) m_cred = eff(w);
                m_owner = w;
                m_prev  = w;
                m_low   = 0;
            end
        end else if (req[m_owner]) begin
            m_low = 0;
            if (slv_ready && last[m_owner]) begin
                if (m_cred > 1) begin
                    m_cred = m_cred - 1;
                    m_ptr  = m_owner;
                end else begin
                    m_cred = 0;
                    m_ptr  = (m_owner + 1) % N;
                end
                m_owner = -1;
            end
        end else begin
            m_low = m_low + 1;
            if (m_low == TO) begin
                m_abort = 1'b1;
                m_ptr   = (m_owner + 1) % N;
                m_cred  = 0;
                m_owner = -1;
                m_low   = 0;
            end
        end
    endtask

    int eg;
    always @(negedge clk) begin
        if (cmp_en && rst_an) begin
            eg = (m_owner < 0) ? 0 : (1 << m_owner);
            chk("grant", grant, eg);
            chk("busy", busy, m_owner >= 0);
            if (m_owner >= 0) chk("gnt_idx", gnt_idx, m_owner);
            chk("beat", beat, (m_owner >= 0) && req[m_owner] && slv_ready);
            chk("abort", abort, m_abort);
            chk("onehot", $onehot0(grant), 1);
        end
    end

    // Inputs change 2 time units after a rising edge; beat is sampled before the next edge.
    task automatic step(input logic [N-1:0] r, input logic [N-1:0] l, input logic rd);
        req = r;
        last = l;
        slv_ready = rd;
        #1;
        if (beat) beat_cnt++;
        @(posedge clk);
        model_step();
        #2;
        if (abort) abort_seen++;
    endtask

    task automatic do_reset();
        rst_an = 1'b0;
        req = '0;
        last = '0;
        slv_ready = 1'b1;
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_idx", gnt_idx, 0);
        chk("rst_abort", abort, 0);
        repeat (2) @(posedge clk);
        #2;
        model_reset();
        rst_an = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int order2 [9];
        int order6 [4];
        int ab_at;
        logic [N-1:0] g_at_abort;
        logic [N-1:0] fixed;
        logic [N-1:0] r;
        int mode;
        int len;

        order2 = '{0, 0, 0, 1, 2, 3, 0, 0, 0};
        order6 = '{0, 1, 0, 1};
        rst_an = 1'b0;
        cfg_weight = {3'd1, 3'd1, 3'd1, 3'd1};
        do_reset();
        cmp_en = 1'b1;

        // Alternation between two single-beat requesters.
        step(4'b1010, 4'b1010, 1'b1); chk("t1_g0", grant, 4'b0010);
        step(4'b1010, 4'b1010, 1'b1); chk("t1_gap0", grant, 4'b0000);
        step(4'b1010, 4'b1010, 1'b1); chk("t1_g1", grant, 4'b1000);
        step(4'b1010, 4'b1010, 1'b1); chk("t1_gap1", grant, 4'b0000);
        step(4'b1010, 4'b1010, 1'b1); chk("t1_g2", grant, 4'b0010);

        // Weight 3 on requester 0.
        cfg_weight = {3'd1, 3'd1, 3'd1, 3'd3};
        do_reset();
        for (int k = 0; k < 9; k++) begin
            step(4'b1111, 4'b1111, 1'b1);
            chk("t2_busy", busy, 1);
            chk("t2_order", gnt_idx, order2[k]);
            step(4'b1111, 4'b1111, 1'b1);
            chk("t2_gap", busy, 0);
        end

        // Four-beat burst with a five-cycle stall.
        cfg_weight = {3'd1, 3'd1, 3'd1, 3'd1};
        do_reset();
        step(4'b0100, 4'b0000, 1'b1); chk("t3_grant", grant, 4'b0100);
        beat_cnt = 0;
        abort_seen = 0;
        step(4'b0100, 4'b0000, 1'b1);
        step(4'b0100, 4'b0000, 1'b1);
        repeat (5) step(4'b0100, 4'b0000, 1'b0);
        chk("t3_held", grant, 4'b0100);
        step(4'b0100, 4'b0000, 1'b1);
        chk("t3_held2", grant, 4'b0100);
        step(4'b0100, 4'b0100, 1'b1);
        chk("t3_drop", grant, 4'b0000);
        chk("t3_beats", beat_cnt, 4);
        chk("t3_noabort", abort_seen, 0);

        // Owner 1 goes silent mid-burst; requester 2 waits.
        do_reset();
        step(4'b0010, 4'b0000, 1'b1); chk("t4_grant", grant, 4'b0010);
        step(4'b0010, 4'b0000, 1'b1);
        ab_at = -1;
        g_at_abort = '1;
        for (int k = 1; k <= 24; k++) begin
            if (ab_at < 0) begin
                step(4'b0100, 4'b0000, 1'b1);
                if (abort) begin
                    ab_at = k;
                    g_at_abort = grant;
                end
            end
        end
        chk("t4_abort_cycle", ab_at, 16);
        chk("t4_grant_drop", g_at_abort, 4'b0000);
        step(4'b0100, 4'b0000, 1'b1);
        chk("t4_pulse_end", abort, 0);
        chk("t4_next", grant, 4'b0100);

        // Asynchronous reset while requester 3 owns with credit left.
        cfg_weight = {3'd3, 3'd1, 3'd1, 3'd1};
        do_reset();
        step(4'b1000, 4'b1000, 1'b1);
        step(4'b1000, 4'b1000, 1'b1);
        step(4'b1000, 4'b1000, 1'b1);
        chk("t5_busy", grant, 4'b1000);
        rst_an = 1'b0;
        #1;
        chk("t5_async_grant", grant, 4'b0000);
        chk("t5_async_busy", busy, 0);
        repeat (2) @(posedge clk);
        #2;
        model_reset();
        rst_an = 1'b1;
        step(4'b1001, 4'b1001, 1'b1);
        chk("t5_after", grant, 4'b0001);

        // Weight 0 behaves as 1.
        cfg_weight = {3'd1, 3'd1, 3'd0, 3'd1};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step(4'b0011, 4'b0011, 1'b1);
            chk("t6_order", gnt_idx, order6[k]);
            step(4'b0011, 4'b0011, 1'b1);
        end

        // Randomized traffic against the model.
        do_reset();
        for (int s = 0; s < 200; s++) begin
            cfg_weight = N*WW'($urandom);
            mode = int'($urandom_range(0, 3));
            len = int'($urandom_range(8, 30));
            fixed = N'($urandom);
            if (mode == 2 && len < 20) len = 20;
            for (int c = 0; c < len; c++) begin
                case (mode)
                    0: r = N'($urandom);
                    1: r = fixed;
                    2: r = N'($urandom) & ~((m_owner >= 0) ? N'(1 << m_owner) : N'(0));
                    default: r = N'($urandom) | fixed;
                endcase
                step(r, N'($urandom), (mode == 3) ? ($urandom_range(0, 3) == 0)
                                                  : ($urandom_range(0, 3) != 0));
            end
            if (s == 100) do_reset();
        end

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/wrr_burst_scheduler.md
Name: wrr_burst_scheduler

Overview:
- Grants one shared slave port to one of N requesters for a whole burst at a time.
- Arbitration is weighted round-robin: each requester may win up to cfg_weight bursts in a row before priority rotates to the next index.
- Grant is registered and held until the burst's last beat, or until the owner stalls past a timeout.
- Sits between the requester front-ends and the shared port. It drives gnt_idx to the external data/address mux.

Parameters:
N, 4, number of requesters (2..8)
WEIGHT_W, 3, width of each per-requester weight field
TIMEOUT, 16, consecutive cycles the owner's req may stay low mid-burst before the burst is aborted (>=2)

Ports:
clk  input  1  clock
rst_an  input  1  asynchronous active-low reset
req  input  N  per-requester request; held high for every beat offered
last  input  N  per-requester last-beat flag, qualified by req
slv_ready  input  1  shared port accepts a beat this cycle
cfg_weight  input  N*WEIGHT_W  bursts per turn; field i is at [i*WEIGHT_W +: WEIGHT_W]; value 0 is treated as 1
grant  output  N  registered one-hot grant
gnt_idx  output  $clog2(N)  index of the owner; valid while busy
busy  output  1  a burst is owned (equals |grant)
beat  output  1  combinational; high when busy & req[gnt_idx] & slv_ready
abort  output  1  registered one-cycle pulse on timeout abort

Behaviour:
- Interface: reset rst_an, asynchronous, active-low; clock clk.
- Reset values:
  - grant=0, gnt_idx=0, busy=0, abort=0.
  - Rotation pointer ptr=0, burst counter cnt=0, timeout counter tcnt=0, state IDLE.
  - An assertion mid-burst drops grant immediately. No completion is reported.
- State IDLE (grant=0):
  - If |req, the winner w is the first requesting index found searching upward from ptr, with wrap-around.
  - Next cycle: grant=onehot(w), gnt_idx=w, state BUSY. This gives 1-cycle grant latency.
  - If w!=gnt_idx or cnt==0, cnt is reloaded with the effective weight of w, sampled at this moment. Otherwise cnt is kept.
- State BUSY:
  - A beat transfers when beat=1.
  - On a beat with last[gnt_idx]=1:
    - grant<=0 and state<=IDLE. This guarantees at least one dead cycle between bursts.
    - If cnt>1: cnt<=cnt-1 and ptr<=gnt_idx, so the same requester keeps priority.
    - Else: cnt<=0 and ptr<=gnt_idx+1 mod N.
  - last on a non-granted requester is ignored.
  - slv_ready low stalls the burst. It has no effect on tcnt.
- Timeout:
  - In BUSY, tcnt increments each cycle req[gnt_idx]==0 and clears on any cycle req[gnt_idx]==1.
  - When tcnt reaches TIMEOUT-1 with req still low:
    - grant<=0, state<=IDLE, ptr<=gnt_idx+1, cnt<=0, tcnt<=0.
    - abort pulses high for exactly one cycle, aligned with grant dropping.
- Arithmetic and fields:
  - ptr wraps mod N. For non-power-of-2 N, increment with an explicit compare to N-1.
  - cnt is WEIGHT_W bits wide and never underflows.
- Simultaneous events:
  - Requests arriving while BUSY are not considered until IDLE.
  - In IDLE, req changes take effect the same cycle; there is no request registering.
- Invariants: grant is always one-hot or zero, and beat is never high when busy=0.

Test Plan:
- Reset then req=4'b1010, all weights=1, single-beat bursts (last=req) -> grants 4'b0010, then 4'b1000, then 4'b0010. Each grant lasts 1 cycle, separated by 1 idle cycle.
- req=4'b1111 continuously, weight[0]=3, others 1, single-beat bursts -> grant order 0,0,0,1,2,3,0,0,0.
- Owner 2 in a 4-beat burst, slv_ready low for 5 cycles mid-burst -> grant held. Exactly 4 beat pulses. Grant drops the cycle after the 4th beat. abort never asserts.
- Owner 1 drops req mid-burst, TIMEOUT=16 -> abort pulses for 1 cycle 16 cycles after req fell. Grant drops the same cycle. Next grant goes to index 2 if requesting.
- rst_an asserted while busy with ptr=3, cnt=2 -> grant=0 asynchronously. After release, req=4'b1001 grants index 0 first.
- weight[1]=0, req=4'b0011, single-beat bursts -> alternation 0,1,0,1 (weight 0 behaves as 1).
